universal_shift_reg: RTL and testbench

Parametrised universal shift register: the next generation of the team's fixed 4-bit parallel-in/parallel-out register. It adds configurable width, parallel load, left/right shift with serial in/out, optional rotate, synchronous clear, and a shift counter that flags each completed word. It serves as the common serializer/deserializer and holding-register primitive in the shift-register library.

---
 rtl/universal_shift_reg.sv | 108 ++++++++++
 tb/tb_universal_shift_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: load, shift/rotate with serial taps, clear, and a
// per-word shift counter. Define ROTATE_EN to build the rotate datapath (modes 100/101).
module universal_shift_reg #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_l,
    output logic             serial_out_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    typedef enum logic [2:0] {
        ModeHold = 3'b000,
        ModeLoad = 3'b001,
        ModeShl  = 3'b010,
        ModeShr  = 3'b011,
        ModeRotl = 3'b100,
        ModeRotr = 3'b101,
        ModeClr  = 3'b110,
        ModeRsvd = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    mode_e            op;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             is_shift;

    assign op = mode_e'(mode);

    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        is_shift = 1'b0;
        if (en) begin
            case (op)
                ModeLoad: begin
                    q_d   = parallel_in;
                    cnt_d = '0;
                end
                ModeShl: begin
                    q_d      = {q_q[WIDTH-2:0], serial_in_r};
                    is_shift = 1'b1;
                end
                ModeShr: begin
                    q_d      = {serial_in_l, q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
`ifdef ROTATE_EN
                ModeRotl: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    is_shift = 1'b1;
                end
                ModeRotr: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
`endif
                ModeClr: begin
                    q_d   = '0;
                    cnt_d = '0;
                end
                default: ;
            endcase

            // The WIDTH-th shift of a word wraps the count and flags completion.
            if (is_shift) begin
                if (cnt_q == CntLast) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign parallel_out = q_q;
    assign serial_out_l = q_q[WIDTH-1];
    assign serial_out_r = q_q[0];
    assign shift_cnt    = cnt_q;
    assign word_done    = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: 4- and 8-bit instances, directed scenarios then random
// stimulus, all compared against an arithmetic reference model.
module tb_universal_shift_reg;

`ifdef ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en4, en8;
    logic [2:0] mode4, mode8;
    logic [3:0] pin4;
    logic [7:0] pin8;
    logic       sr4, sl4, sr8, sl8;
    logic [3:0] po4;
    logic [7:0] po8;
    logic       sol4, sor4, sol8, sor8;
    logic [2:0] cnt4;
    logic [3:0] cnt8;
    logic       wd4, wd8;

    int checks = 0;
    int errors = 0;

    longint unsigned mq4, mq8;
    int              mc4, mc8;
    bit              md4, md8;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .en(en4), .mode(mode4), .parallel_in(pin4),
        .serial_in_r(sr4), .serial_in_l(sl4), .parallel_out(po4),
        .serial_out_l(sol4), .serial_out_r(sor4), .shift_cnt(cnt4), .word_done(wd4)
    );

    universal_shift_reg #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .en(en8), .mode(mode8), .parallel_in(pin8),
        .serial_in_r(sr8), .serial_in_l(sl8), .parallel_out(po8),
        .serial_out_l(sol8), .serial_out_r(sor8), .shift_cnt(cnt8), .word_done(wd8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: register value as an integer, count as shifts modulo width.
    task automatic model_step(input int w, input bit e, input logic [2:0] m,
                              input longint unsigned pin, input bit sr, input bit sl,
                              inout longint unsigned q, inout int cnt, inout bit done);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        bit shifted = 1'b0;
        done = 1'b0;
        if (!e) return;
        case (m)
            3'd1: begin q = pin & mask; cnt = 0; end
            3'd2: begin q = ((q << 1) | (sr ? 64'd1 : 64'd0)) & mask; shifted = 1'b1; end
            3'd3: begin q = (q >> 1) | ((sl ? 64'd1 : 64'd0) << (w - 1)); shifted = 1'b1; end
            3'd4: if (ROT) begin q = ((q << 1) | (q >> (w - 1))) & mask; shifted = 1'b1; end
            3'd5: if (ROT) begin q = (q >> 1) | ((q & 64'd1) << (w - 1)); shifted = 1'b1; end
            3'd6: begin q = 0; cnt = 0; end
            default: ;
        endcase
        if (shifted) begin
            cnt = cnt + 1;
            if (cnt == w) begin
                cnt  = 0;
                done = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        mq4 = 0; mc4 = 0; md4 = 1'b0;
        mq8 = 0; mc8 = 0; md8 = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_po4"},  po4,  mq4[3:0]);
        check({tag, "_sol4"}, sol4, mq4[3]);
        check({tag, "_sor4"}, sor4, mq4[0]);
        check({tag, "_cnt4"}, cnt4, mc4);
        check({tag, "_wd4"},  wd4,  md4);
        check({tag, "_po8"},  po8,  mq8[7:0]);
        check({tag, "_sol8"}, sol8, mq8[7]);
        check({tag, "_sor8"}, sor8, mq8[0]);
        check({tag, "_cnt8"}, cnt8, mc8);
        check({tag, "_wd8"},  wd8,  md8);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_step(4, en4, mode4, 64'(pin4), sr4, sl4, mq4, mc4, md4);
        model_step(8, en8, mode8, 64'(pin8), sr8, sl8, mq8, mc8, md8);
        check_all(tag);
    endtask

    initial begin
        logic [3:0] shl_exp [4];
        logic [7:0] shr_bits;
        int         pulses;

        shl_exp = '{4'b1010, 4'b0100, 4'b1000, 4'b0000};
        shr_bits = 8'b1011_0010; // fed MSB-first: 1,0,1,1,0,0,1,0

        rst = 1'b0;
        en4 = 1'b0; en8 = 1'b0; mode4 = 3'd0; mode8 = 3'd0;
        pin4 = '0; pin8 = '0; sr4 = 1'b0; sl4 = 1'b0; sr8 = 1'b0; sl8 = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Load then hold with en low.
        en4 = 1'b1; mode4 = 3'd1; pin4 = 4'b1101;
        step("load");
        check("load_const", po4, 4'b1101);
        en4 = 1'b0; mode4 = 3'd2;
        repeat (3) step("hold");
        check("hold_const", po4, 4'b1101);
        check("hold_cnt", cnt4, 3'd0);

        // Shift-left word.
        en4 = 1'b1; mode4 = 3'd1; pin4 = 4'b1101;
        step("shl_load");
        mode4 = 3'd2; sr4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("shl");
            check("shl_po_const", po4, shl_exp[i]);
            check("shl_cnt_const", cnt4, 3'((i + 1) % 4));
            check("shl_wd_const", wd4, (i == 3) ? 1'b1 : 1'b0);
        end
        // Load right after word_done drops the pulse.
        mode4 = 3'd1; pin4 = 4'b0110;
        step("load_after_done");
        check("load_after_done_wd", wd4, 1'b0);

        // Shift-right deserialise on the 8-bit instance.
        en4 = 1'b0;
        en8 = 1'b1; mode8 = 3'd6;
        step("clr8");
        mode8 = 3'd3;
        pulses = 0;
        for (int i = 7; i >= 0; i--) begin
            sl8 = shr_bits[i];
            step("shr8");
            if (wd8) pulses++;
        end
        check("shr8_po_const", po8, 8'b0100_1101);
        check("shr8_pulses", pulses, 1);
        en8 = 1'b0;

        // Rotate.
        en4 = 1'b1; mode4 = 3'd1; pin4 = 4'b1101;
        step("rot_load");
        mode4 = 3'd5;
        step("rotr");
        check("rotr_const", po4, ROT ? 4'b1110 : 4'b1101);
        mode4 = 3'd4;
        step("rotl");
        step("rotl");
        check("rotl_const", po4, ROT ? 4'b1011 : 4'b1101);
        check("rot_cnt_const", cnt4, ROT ? 3'd3 : 3'd0);

        // Asynchronous reset mid-word.
        mode4 = 3'd1; pin4 = 4'b1010;
        step("rst_load");
        mode4 = 3'd2; sr4 = 1'b0;
        step("rst_shl");
        step("rst_shl");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst_po_const", po4, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // Random operation mix, biased towards shifts so words complete.
        for (int n = 0; n < 400; n++) begin
            en4   = ($urandom_range(0, 7) != 0);
            en8   = ($urandom_range(0, 7) != 0);
            mode4 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                : 3'($urandom_range(2, 5));
            mode8 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                : 3'($urandom_range(2, 5));
            pin4  = 4'($urandom);
            pin8  = 8'($urandom);
            sr4   = 1'($urandom); sl4 = 1'($urandom);
            sr8   = 1'($urandom); sl8 = 1'($urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
